// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI mode-0 master: FSM state encoding and the
// default SCLK half-period length in system clocks.
package spi_master_pkg;

  // Default i_clk cycles per SCLK half-period (legal range 2..255).
  localparam int CLK_DIV_DEFAULT = 2;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_START_ENC = 3'd1;
  localparam logic [2:0] ST_LOW_ENC   = 3'd2;
  localparam logic [2:0] ST_HIGH_ENC  = 3'd3;
  localparam logic [2:0] ST_DONE_ENC  = 3'd4;
  localparam logic [2:0] ST_STOP_ENC  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_START = ST_START_ENC,
    ST_LOW   = ST_LOW_ENC,
    ST_HIGH  = ST_HIGH_ENC,
    ST_DONE  = ST_DONE_ENC,
    ST_STOP  = ST_STOP_ENC
  } state_t;

endpackage

// File: rtl/spi_master_if.sv
// Byte handshake between the CPU I/O stage (master modport) and the SPI
// master block (slave modport). Signal names keep the block's pin names.
interface spi_master_if;
  import spi_master_pkg::*;

  logic       i_valid;
  logic [7:0] i_data;
  logic       i_hold;
  logic       o_ready;
  logic       o_rx_valid;
  logic [7:0] o_rx_data;

  modport master (
    output i_valid, i_data, i_hold,
    input  o_ready, o_rx_valid, o_rx_data
  );

  modport slave (
    input  i_valid, i_data, i_hold,
    output o_ready, o_rx_valid, o_rx_data
  );

endinterface

// File: rtl/spi_master_tick.sv
// spi_tick: loadable half-period down-counter. o_tick is high while the count
// sits at zero; the owner reloads on the same cycle, so the tick lasts one cycle.
module spi_tick (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic       o_tick
);

  logic [7:0] cnt;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= 8'd0;
    end else if (i_load) begin
      cnt <= i_load_val;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign o_tick = (cnt == 8'd0);

endmodule

// File: rtl/spi_master.sv
// spi_master: byte-wide SPI mode-0 master for the serial flash. One byte per
// valid/ready handshake; i_hold keeps CS low so multi-byte commands form one
// transaction.
// Build option: define SPI_LOOPBACK_EN to sample o_copi instead of i_cipo
// (RX byte equals TX byte, for bring-up without a flash part).
//
// state | meaning
// IDLE  | ready for a byte, SCLK low, CS low only if the previous byte held it
// START | CS just asserted, first COPI bit set up for one half-period
// LOW   | SCLK low half-period, COPI stable
// HIGH  | SCLK high half-period, CIPO captured at the rising edge
// DONE  | one cycle, RX byte published with o_rx_valid
// STOP  | SCLK low half-period before CS is released
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT  // i_clk cycles per SCLK half-period, 2..255
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  spi_master_if.slave  bus,
  output logic         o_cs,
  output logic         o_sclk,
  output logic         o_copi,
  input  logic         i_cipo
);

  localparam logic [7:0] HALF_LOAD = 8'(CLK_DIV - 1);

  state_t     state;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       hold_q;
  logic       sample;
  logic       cs_q;
  logic       sclk_q;
  logic       copi_q;
  logic       ready_q;
  logic       rx_valid_q;
  logic [7:0] rx_data_q;
  logic       tick;
  logic       tick_load;
  logic       cipo_src;

`ifdef SPI_LOOPBACK_EN
  logic unused_cipo;
  assign unused_cipo = i_cipo;
  assign cipo_src    = copi_q;
`else
  assign cipo_src    = i_cipo;
`endif

  // Every state is entered either from IDLE, from DONE, or on a tick, so
  // reloading in those three situations restarts the half-period on entry.
  assign tick_load = (state == ST_IDLE) || (state == ST_DONE) || tick;

  spi_tick u_tick (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (tick_load),
    .i_load_val (HALF_LOAD),
    .o_tick     (tick)
  );

  // Transfer FSM; all pin and handshake outputs are registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      shift      <= 8'd0;
      bit_cnt    <= 3'd0;
      hold_q     <= 1'b0;
      sample     <= 1'b0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      copi_q     <= 1'b0;
      ready_q    <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          sclk_q <= 1'b0;
          if (bus.i_valid && ready_q) begin
            shift   <= bus.i_data;
            hold_q  <= bus.i_hold;
            bit_cnt <= 3'd0;
            ready_q <= 1'b0;
            copi_q  <= bus.i_data[7];
            if (cs_q) begin
              cs_q  <= 1'b0;
              state <= ST_START;
            end else begin
              state <= ST_LOW;
            end
          end
        end
        ST_START: begin
          if (tick) state <= ST_LOW;
        end
        ST_LOW: begin
          // Already equal to shift[7] on entry; keeps COPI pinned to the MSB.
          copi_q <= shift[7];
          if (tick) begin
            sclk_q <= 1'b1;
            sample <= cipo_src;
            state  <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (tick) begin
            sclk_q  <= 1'b0;
            shift   <= {shift[6:0], sample};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_valid_q <= 1'b1;
              rx_data_q  <= {shift[6:0], sample};
              state      <= ST_DONE;
            end else begin
              // Next bit goes out on the falling edge.
              copi_q <= shift[6];
              state  <= ST_LOW;
            end
          end
        end
        ST_DONE: begin
          if (hold_q) begin
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            cs_q    <= 1'b1;
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cs           = cs_q;
  assign o_sclk         = sclk_q;
  assign o_copi         = copi_q;
  assign bus.o_ready    = ready_q;
  assign bus.o_rx_valid = rx_valid_q;
  assign bus.o_rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: an external device answers with the registered
// inverse of COPI (or the loopback build with CIPO tied low); expected RX
// bytes and pulse cycles are queued at accept and checked on o_rx_valid.
module tb_spi_master;
  import spi_master_pkg::*;

  localparam int DIV = 2;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs, sclk, copi, cipo, cipo_r;

  always #5 clk = ~clk;

  spi_master_if bus();

  spi_master #(.CLK_DIV(DIV)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave),
    .o_cs    (cs),
    .o_sclk  (sclk),
    .o_copi  (copi),
    .i_cipo  (cipo)
  );

  // external device: registered inverse of COPI
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cipo_r <= 1'b0;
    else        cipo_r <= ~copi;
  end

`ifdef SPI_LOOPBACK_EN
  assign cipo = 1'b0;
`else
  assign cipo = cipo_r;
`endif

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rx_cnt = 0;
  int   rx_last_cyc = 0;
  int   rises = 0;
  int   cs_rises = 0;
  logic sclk_prev = 1'b0;
  logic cs_prev = 1'b1;
  logic model_cs_low = 1'b0;
  exp_t sbq[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] expected_rx(input logic [7:0] tx);
`ifdef SPI_LOOPBACK_EN
    return tx;
`else
    return ~tx;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // edge counters and RX scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (sclk && !sclk_prev) rises++;
    if (cs && !cs_prev) cs_rises++;
    sclk_prev = sclk;
    cs_prev = cs;
    if (rst_n && bus.o_rx_valid) begin
      rx_cnt++;
      rx_last_cyc = cyc;
      if (sbq.size() == 0) begin
        check("rx_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("rx_data", 32'(bus.o_rx_data), 32'(mon_e.data));
        check("rx_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic h);
    int   n;
    bit   done;
    int   lat;
    exp_t e;
    n = 0;
    done = 0;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_hold  = h;
    while (!done && n < 2000) begin
      if (bus.o_ready) begin
        lat = model_cs_low ? 1 + 16 * DIV : 1 + 17 * DIV;
        e.data = expected_rx(d);
        e.cyc  = cyc + lat;
        sbq.push_back(e);
        model_cs_low = h;
        done = 1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    int n;
    n = 0;
    while (rx_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rx_count", 32'(rx_cnt), 32'(target));
  endtask

  task automatic wait_until(input int c);
    int n;
    n = 0;
    while (cyc < c && n < 3000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int r0;
    int c0;
    int n;
    logic [7:0] b;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    bus.i_hold  = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_copi", 32'(copi), 32'd0);
    check("rst_ready", 32'(bus.o_ready), 32'd1);
    check("rst_rx_valid", 32'(bus.o_rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus.o_rx_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.o_ready), 32'd1);

    // cold single byte, no hold
    r0 = rises;
    send(8'hA5, 1'b0);
    wait_rx(1);
    check("sclk_rises", 32'(rises - r0), 32'd8);
    wait_until(rx_last_cyc + 1 + DIV - 1);
    check("stop_cs_low", 32'(cs), 32'd0);
    check("stop_ready", 32'(bus.o_ready), 32'd0);
    wait_until(rx_last_cyc + 1 + DIV);
    check("cs_release", 32'(cs), 32'd1);
    check("ready_after_stop", 32'(bus.o_ready), 32'd1);

    // held two-byte transaction
    c0 = cs_rises;
    send(8'h03, 1'b1);
    wait_rx(2);
    wait_until(rx_last_cyc + 1);
    check("hold_ready", 32'(bus.o_ready), 32'd1);
    check("hold_cs", 32'(cs), 32'd0);
    send(8'h00, 1'b0);
    wait_rx(3);
    wait_until(rx_last_cyc + 1 + DIV);
    check("hold_cs_rises", 32'(cs_rises - c0), 32'd1);

    // valid pulsed mid-transfer is ignored
    send(8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    check("busy_ready", 32'(bus.o_ready), 32'd0);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'hFF;
    @(negedge clk);
    bus.i_valid = 1'b0;
    wait_rx(4);
    repeat (60) @(negedge clk);
    check("ignored_valid_rx_count", 32'(rx_cnt), 32'd4);

    // reset during bit 4
    r0 = rises;
    send(8'h96, 1'b0);
    n = 0;
    while (rises - r0 < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit4", 32'(rises - r0), 32'd4);
    rst_n = 1'b0;
    #1;
    check("midrst_cs", 32'(cs), 32'd1);
    check("midrst_sclk", 32'(sclk), 32'd0);
    check("midrst_ready", 32'(bus.o_ready), 32'd1);
    sbq.delete();
    model_cs_low = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_no_rx", 32'(rx_cnt), 32'd4);
    send(8'h5B, 1'b0);
    wait_rx(5);

    // a few random bytes with random hold
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      send(b, (i == 3) ? 1'b0 : 1'($urandom_range(0, 1)));
      wait_rx(6 + i);
    end
    wait_until(rx_last_cyc + 1 + DIV);
    check("final_cs", 32'(cs), 32'd1);
    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
